// File: rtl/comp_search_ctrl.sv
// Binary-search driver for an external magnitude comparator: steps operand B
// until the comparator reports A==B, then reports A's value and the compare count.
//
// state | meaning
// IDLE  | waiting for start
// DRIVE | B held on the comparator; flags sampled and decided on the last wait cycle
// FIN   | one-cycle done (and error) pulse
module comp_search_ctrl #(
  parameter int WIDTH   = 3,
  parameter int CMP_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          A_greater_B,
  input  logic                          A_equal_B,
  input  logic                          A_less_B,
  output logic [WIDTH-1:0]              B,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(WIDTH+2)-1:0]    steps
);

  localparam int SW = $clog2(WIDTH+2);
  localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(CMP_LAT - 1);
  localparam logic [WIDTH:0] ONE_W    = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] HI_INIT  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [SW-1:0]  ONE_S    = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DRIVE, FIN} state_t;

  state_t            state, state_nxt;
  logic [WIDTH:0]    lo, lo_nxt, hi, hi_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [WIDTH-1:0]  b_nxt, result_nxt;
  logic [SW-1:0]     steps_nxt;
  logic              busy_nxt, done_nxt, error_nxt, fail;

  // lo/hi carry one extra bit so midpoint sums never wrap
  logic [WIDTH:0] b_ext, sum_gt, sum_lt;
  assign b_ext  = {1'b0, B};
  assign sum_gt = b_ext + ONE_W + hi;
  assign sum_lt = lo + b_ext - ONE_W;

  always_comb begin
    state_nxt  = state;
    lo_nxt     = lo;
    hi_nxt     = hi;
    cnt_nxt    = cnt;
    b_nxt      = B;
    result_nxt = result;
    steps_nxt  = steps;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    error_nxt  = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lo_nxt     = '0;
          hi_nxt     = HI_INIT;
          steps_nxt  = '0;
          result_nxt = '0;
          b_nxt      = WIDTH'(HI_INIT >> 1);
          busy_nxt   = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          steps_nxt = steps + ONE_S;
          case ({A_greater_B, A_equal_B, A_less_B})
            3'b010: begin
              result_nxt = B;
              busy_nxt   = 1'b0;
              done_nxt   = 1'b1;
              state_nxt  = FIN;
            end
            3'b100: begin
              if (b_ext == hi) fail = 1'b1;
              else begin
                lo_nxt = b_ext + ONE_W;
                b_nxt  = WIDTH'(sum_gt >> 1);
              end
            end
            3'b001: begin
              if (b_ext == lo) fail = 1'b1;
              else begin
                hi_nxt = b_ext - ONE_W;
                b_nxt  = WIDTH'(sum_lt >> 1);
              end
            end
            default: fail = 1'b1;
          endcase
          if (fail) begin
            result_nxt = '0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            error_nxt  = 1'b1;
            state_nxt  = FIN;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
      B      <= '0;
      result <= '0;
      steps  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else begin
      state  <= state_nxt;
      lo     <= lo_nxt;
      hi     <= hi_nxt;
      cnt    <= cnt_nxt;
      B      <= b_nxt;
      result <= result_nxt;
      steps  <= steps_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      error  <= error_nxt;
    end
  end

endmodule

// File: doc/comp_search_ctrl.md
Name: comp_search_ctrl

Overview:
Sequential binary-search controller that sits on the driving side of a magnitude comparator. It drives operand B into an external comparator, whose other operand A holds an unknown value. It samples the three comparator flags and narrows the search range until the flags report equality. It then returns A's value as result, together with the number of compares used. It is used as a self-checking consumer of the comparator block and as a successive-approximation value finder.

Parameters:
WIDTH, 3, operand width of A/B in bits.
CMP_LAT, 1, cycles B is held before flags are sampled (≥1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  begin a search; sampled only in IDLE.
A_greater_B  in  1  comparator flag A>B.
A_equal_B  in  1  comparator flag A==B.
A_less_B  in  1  comparator flag A<B.
B  out  WIDTH  current guess driven to comparator, registered.
busy  out  1  high while a search is in progress.
done  out  1  one-cycle pulse: search finished (success or error).
error  out  1  one-cycle pulse with done: search failed.
result  out  WIDTH  found value, held until next start.
steps  out  clog2(WIDTH+2)  number of compares performed, held until next start.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous, active-high, and takes priority over all other inputs.
- Reset values:
  - B=0, busy=0, done=0, error=0, result=0, steps=0.
  - State IDLE.
- Internal registers:
  - lo and hi, each WIDTH+1 bits, so the range cannot wrap.
  - Wait counter running 0..CMP_LAT-1.
  - Compare counter.
- States:
  - IDLE: if start=1, load lo=0, hi=2^WIDTH-1, steps=0, result=0, B=(lo+hi)>>1 (the midpoint), busy=1, then go to DRIVE.
  - DRIVE: hold B for CMP_LAT cycles. At the edge ending the CMP_LAT-th cycle, sample the flags, increment steps, go to EVAL.
  - EVAL: this is the decision made on the sample edge, not a visible extra cycle. Flags must be exactly one-hot.
    - equal: result=B, go to FIN with error=0.
    - greater: if B==hi, this is an error. Otherwise lo=B+1, B=(B+1+hi)>>1, go back to DRIVE.
    - less: if B==lo, this is an error. Otherwise hi=B-1, B=(lo+B-1)>>1, go back to DRIVE.
    - Flags not one-hot (none set, or more than one set): error.
    - On any error: result=0, go to FIN with error=1.
  - FIN: done=1 for exactly one cycle, with error as decided in EVAL. busy=0 from this cycle. Return to IDLE. B keeps its last value.
- Latency:
  - With start sampled high in cycle 0, done is high in cycle N·CMP_LAT+1, where N is the number of compares.
  - N ≤ WIDTH+1.
- start handling:
  - start while busy=1 is ignored.
  - start held high continuously starts a new search in the IDLE cycle after FIN.
- Reset mid-operation:
  - Search is abandoned immediately, all outputs return to reset values, no done pulse.
- Flag inputs are ignored outside the sample edge.

Test Plan:
1. Comparator model with A=3, WIDTH=3, CMP_LAT=1, pulse start in cycle 0 -> B=3 in cycle 1; done=1, error=0, result=3, steps=1 in cycle 2.
2. A=7 -> B sequence 3,5,6,7; done in cycle 5 with result=7, steps=4, error=0.
3. A=0 -> B sequence 3,1,0; result=0, steps=3; repeat with CMP_LAT=3 -> B held 3 cycles each, done in cycle 10.
4. Force flags 2'b00 (none set) and separately greater+less both high at the first sample -> done=1, error=1, result=0, steps=1; also force greater constantly -> error at B==7 with steps=4.
5. Assert rst during DRIVE of the second compare for A=7 -> next cycle B=0, busy=0, no done pulse; a subsequent start completes normally.
6. Pulse start again while busy -> ignored, sequence unchanged; start held high -> back-to-back searches, each with a one-cycle done and an IDLE cycle between them.
